// File: rtl/mux_reg_nto1_if.sv
// Bundle of the channel-mux handshake: packed input channels, select/valid/ready upstream,
// registered result with valid/ready downstream, plus the sticky select-error flag.
interface mux_reg_nto1_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   select;
    logic               in_valid;
    logic               in_ready;
    logic               rr_mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;
    logic               err_clr;

    modport master (
        output in_data, select, in_valid, rr_mode, out_ready, err_clr,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport slave (
        input  in_data, select, in_valid, rr_mode, out_ready, err_clr,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );
endinterface

// File: rtl/mux_reg_nto1.sv
// N-to-1 registered channel mux with a single-entry valid/ready output buffer.
// Optional round-robin auto-select is compiled in with `define MUX_REG_RR_EN.
module mux_reg_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    mux_reg_nto1_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    if ((2 ** SEL_W) < N) begin : g_bad_sel_w
        $error("mux_reg_nto1: SEL_W too narrow for N");
    end
    if ((N < 2) || (N > 16)) begin : g_bad_n
        $error("mux_reg_nto1: N must be in 2..16");
    end

    logic [0:0]       state_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             sel_err_r;

    logic [SEL_W-1:0] sel_eff_s;
    logic [31:0]      sel_ext_s;
    logic             sel_oor_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] chan_data_s;

`ifdef MUX_REG_RR_EN
    logic [SEL_W-1:0] rr_ptr_r;

    // Effective select: pointer in round-robin mode, otherwise the upstream select
    always_comb begin
        sel_eff_s = bus.select;
        if (bus.rr_mode) begin
            sel_eff_s = rr_ptr_r;
        end else begin
            sel_eff_s = bus.select;
        end
    end

    // Round-robin pointer advances only on accepts made in round-robin mode
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= {SEL_W{1'b0}};
        end else if (accept_s && bus.rr_mode) begin
            if (rr_ptr_r == SEL_W'(N - 1)) begin
                rr_ptr_r <= {SEL_W{1'b0}};
            end else begin
                rr_ptr_r <= rr_ptr_r + SEL_W'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    logic unused_rr_mode_s;
    assign unused_rr_mode_s = bus.rr_mode;

    // Without the round-robin feature the upstream select is always used
    always_comb begin
        sel_eff_s = bus.select;
    end
`endif

    assign sel_ext_s  = 32'(sel_eff_s);
    assign sel_oor_s  = (sel_ext_s >= 32'(N));
    assign in_ready_s = (state_r == ST_EMPTY) || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // One-hot OR mux; an out-of-range select matches no channel and yields zero
    always_comb begin
        chan_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < N; k++) begin
            chan_data_s = chan_data_s
                        | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{sel_eff_s == SEL_W'(k)}});
        end
    end

    // Output buffer: load on accept, drain on out_ready, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            out_data_r <= {WIDTH{1'b0}};
            out_sel_r  <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            state_r    <= ST_FULL;
            out_data_r <= sel_oor_s ? {WIDTH{1'b0}} : chan_data_s;
            out_sel_r  <= sel_eff_s;
        end else if (bus.out_ready) begin
            state_r    <= ST_EMPTY;
            out_data_r <= out_data_r;
            out_sel_r  <= out_sel_r;
        end else begin
            state_r    <= state_r;
            out_data_r <= out_data_r;
            out_sel_r  <= out_sel_r;
        end
    end

    // Sticky select error; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && sel_oor_s) begin
            sel_err_r <= 1'b1;
        end else if (bus.err_clr) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = (state_r == ST_FULL);
    assign bus.sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_reg_nto1.sv
// Directed bench for mux_reg_nto1: a 4-channel and a 3-channel instance share clock and reset.
// Round-robin vectors are used when MUX_REG_RR_EN is defined, pass-through vectors otherwise.
module tb_mux_reg_nto1;

    logic clk;
    logic reset;
    int   checks_cnt;
    int   fail_cnt;

    mux_reg_nto1_if #(.WIDTH(32), .N(4), .SEL_W(2)) a_if ();
    mux_reg_nto1_if #(.WIDTH(32), .N(3), .SEL_W(2)) b_if ();

    mux_reg_nto1 #(.WIDTH(32), .N(4), .SEL_W(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    mux_reg_nto1 #(.WIDTH(32), .N(3), .SEL_W(2)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        reset      = 1'b1;
        a_if.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        a_if.select    = 2'd0;
        a_if.in_valid  = 1'b0;
        a_if.rr_mode   = 1'b0;
        a_if.out_ready = 1'b0;
        a_if.err_clr   = 1'b0;
        b_if.in_data   = {32'h333, 32'h222, 32'h111};
        b_if.select    = 2'd0;
        b_if.in_valid  = 1'b0;
        b_if.rr_mode   = 1'b0;
        b_if.out_ready = 1'b1;
        b_if.err_clr   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check_eq("rst_out_valid", a_if.out_valid, 64'd0);
        check_eq("rst_out_data",  a_if.out_data,  64'd0);
        check_eq("rst_out_sel",   a_if.out_sel,   64'd0);
        check_eq("rst_sel_err",   a_if.sel_err,   64'd0);
        check_eq("rst_in_ready",  a_if.in_ready,  64'd1);

        // Accept channel 2 with downstream stalled
        a_if.select   = 2'd2;
        a_if.in_valid = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        check_eq("acc_data",      a_if.out_data,  64'h33);
        check_eq("acc_sel",       a_if.out_sel,   64'd2);
        check_eq("acc_valid",     a_if.out_valid, 64'd1);
        check_eq("stall_ready",   a_if.in_ready,  64'd0);

        // Offer blocked while stalled: buffer must hold
        a_if.select   = 2'd1;
        a_if.in_valid = 1'b1;
        tick();
        check_eq("hold_data",     a_if.out_data,  64'h33);
        check_eq("hold_sel",      a_if.out_sel,   64'd2);
        check_eq("hold_valid",    a_if.out_valid, 64'd1);

        // Replace without bubble
        a_if.out_ready = 1'b1;
        a_if.select    = 2'd3;
        #1;
        check_eq("drain_ready",   a_if.in_ready,  64'd1);
        tick();
        a_if.in_valid = 1'b0;
        check_eq("repl_data",     a_if.out_data,  64'h44);
        check_eq("repl_sel",      a_if.out_sel,   64'd3);
        check_eq("repl_valid",    a_if.out_valid, 64'd1);
        tick();
        check_eq("empty_valid",   a_if.out_valid, 64'd0);
        check_eq("empty_ready",   a_if.in_ready,  64'd1);

        // No accept: select/data changes are ignored
        a_if.select  = 2'd0;
        a_if.in_data = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
        tick();
        check_eq("idle_valid",    a_if.out_valid, 64'd0);
        a_if.in_valid = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        check_eq("ch0_data",      a_if.out_data,  64'hAA);
        a_if.in_data = {32'h44, 32'h33, 32'h22, 32'h11};

        // Out-of-range select on the 3-channel instance
        b_if.select   = 2'd3;
        b_if.in_valid = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check_eq("oor_data",      b_if.out_data,  64'd0);
        check_eq("oor_sel",       b_if.out_sel,   64'd3);
        check_eq("oor_valid",     b_if.out_valid, 64'd1);
        check_eq("oor_err",       b_if.sel_err,   64'd1);
        tick();
        check_eq("err_sticky",    b_if.sel_err,   64'd1);
        b_if.select   = 2'd2;
        b_if.in_valid = 1'b1;
        tick();
        check_eq("b_ch2_data",    b_if.out_data,  64'h333);
        check_eq("err_persist",   b_if.sel_err,   64'd1);
        b_if.select  = 2'd3;
        b_if.err_clr = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check_eq("err_set_wins",  b_if.sel_err,   64'd1);
        tick();
        b_if.err_clr = 1'b0;
        check_eq("err_cleared",   b_if.sel_err,   64'd0);
        b_if.in_valid = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check_eq("err_reset_pre", b_if.sel_err,   64'd1);

`ifdef MUX_REG_RR_EN
        // Round-robin sequence ignores select
        a_if.rr_mode   = 1'b1;
        a_if.select    = 2'd2;
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_sel;
            exp_sel = 2'(i % 4);
            tick();
            check_eq("rr_sel",  a_if.out_sel,  64'(exp_sel));
            check_eq("rr_data", a_if.out_data, 64'(32'h11 * (32'(exp_sel) + 32'd1)));
        end
        a_if.rr_mode = 1'b0;
        a_if.select  = 2'd0;
        tick();
        check_eq("rr_off_sel",    a_if.out_sel,   64'd0);
        a_if.rr_mode = 1'b1;
        a_if.select  = 2'd1;
        tick();
        check_eq("rr_resume_sel", a_if.out_sel,   64'd2);
        check_eq("rr_resume_dat", a_if.out_data,  64'h33);
        a_if.in_valid = 1'b0;
        a_if.rr_mode  = 1'b0;
        tick();
`else
        // rr_mode has no effect in the default build
        a_if.rr_mode   = 1'b1;
        a_if.out_ready = 1'b1;
        a_if.select    = 2'd2;
        a_if.in_valid  = 1'b1;
        tick();
        check_eq("norr_sel2",     a_if.out_sel,   64'd2);
        check_eq("norr_data2",    a_if.out_data,  64'h33);
        a_if.select = 2'd1;
        tick();
        check_eq("norr_sel1",     a_if.out_sel,   64'd1);
        check_eq("norr_data1",    a_if.out_data,  64'h22);
        a_if.in_valid = 1'b0;
        a_if.rr_mode  = 1'b0;
        tick();
`endif

        // Reset while FULL discards the buffered transfer
        a_if.out_ready = 1'b0;
        a_if.select    = 2'd1;
        a_if.in_valid  = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        check_eq("pre_rst_valid", a_if.out_valid, 64'd1);
        check_eq("pre_rst_data",  a_if.out_data,  64'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_valid", a_if.out_valid, 64'd0);
        check_eq("mid_rst_data",  a_if.out_data,  64'd0);
        check_eq("mid_rst_sel",   a_if.out_sel,   64'd0);
        check_eq("mid_rst_ready", a_if.in_ready,  64'd1);
        check_eq("mid_rst_err",   b_if.sel_err,   64'd0);
        tick();
        check_eq("post_rst_valid", a_if.out_valid, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
